// File: rtl/rsa_sched.sv
// rsa_sched: two-requester front end for a modular-exponentiation engine.
// It arbitrates round-robin between requesters, hands the winner's operands
// to the engine, waits for completion under a watchdog, and returns the
// result on the granted requester's response port.
//
// Handshakes: reqk_ready is a one-cycle acceptance pulse, raised only in IDLE
// for the requester that wins arbitration, and the job transfers on that
// cycle. rspk_valid stays high, with rsp_result/rsp_err held stable, until the
// same requester raises rspk_ready. The response transfers on the cycle where
// both are high. rspk_ready from the other requester has no effect.
module rsa_sched #(
    parameter int base_width = 6,
    parameter int expo_width = 6,
    parameter int N_width    = 6,
    parameter int TO_CYCLES  = 80
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    input  logic [base_width-1:0] req0_base,
    input  logic [base_width-1:0] req1_base,
    input  logic [expo_width-1:0] req0_expo,
    input  logic [expo_width-1:0] req1_expo,
    input  logic [N_width-1:0]    req0_N,
    input  logic [N_width-1:0]    req1_N,
    output logic                  req0_ready,
    output logic                  req1_ready,
    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    input  logic                  rsp0_ready,
    input  logic                  rsp1_ready,
    output logic [N_width-1:0]    rsp_result,
    output logic                  rsp_err,
    output logic                  eng_start,
    output logic [base_width-1:0] eng_base,
    output logic [expo_width-1:0] eng_expo,
    output logic [N_width-1:0]    eng_N,
    input  logic [N_width-1:0]    eng_result,
    input  logic                  eng_valid
);

    localparam int WD_W = $clog2(TO_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  gnt_q, gnt_d;     // requester currently being served
    logic                  last_q, last_d;   // requester granted most recently
    logic [base_width-1:0] base_q, base_d;
    logic [expo_width-1:0] expo_q, expo_d;
    logic [N_width-1:0]    n_q, n_d;
    logic [N_width-1:0]    res_q, res_d;
    logic                  err_q, err_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  any_req;
    logic                  pick;

    // Round-robin choice: on a tie the requester not granted last wins.
    always_comb begin
        any_req = (req0_valid | req1_valid) & ~rst;
        pick    = 1'b0;
        if (req0_valid && req1_valid) begin
            pick = ~last_q;
        end else begin
            pick = req1_valid;
        end
    end

    // Next-state logic and Moore/Mealy outputs of the job FSM.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        base_d     = base_q;
        expo_d     = expo_q;
        n_d        = n_q;
        res_d      = res_q;
        err_d      = err_q;
        wd_d       = wd_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        eng_start  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    req0_ready = ~pick;
                    req1_ready = pick;
                    gnt_d      = pick;
                    last_d     = pick;
                    base_d     = pick ? req1_base : req0_base;
                    expo_d     = pick ? req1_expo : req0_expo;
                    n_d        = pick ? req1_N    : req0_N;
                    state_d    = S_START;
                end
            end
            S_START: begin
                eng_start = 1'b1;
                wd_d      = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A completing engine beats a watchdog expiring in the same cycle.
                if (eng_valid) begin
                    res_d   = eng_result;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wd_q == WD_W'(TO_CYCLES - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RESP: begin
                rsp0_valid = ~gnt_q;
                rsp1_valid = gnt_q;
                if ((!gnt_q && rsp0_ready) || (gnt_q && rsp1_ready)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset leaves requester 1 as last grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            base_q  <= '0;
            expo_q  <= '0;
            n_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            base_q  <= base_d;
            expo_q  <= expo_d;
            n_q     <= n_d;
            res_q   <= res_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign eng_base   = base_q;
    assign eng_expo   = expo_q;
    assign eng_N      = n_q;
    assign rsp_result = res_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_rsa_sched.sv
// tb_rsa_sched: directed bench for rsa_sched with a behavioural engine,
// per-port expected-response queues and a negedge monitor.
module tb_rsa_sched;

    localparam int BW = 6;
    localparam int EW = 6;
    localparam int NW = 6;
    localparam int TO = 20;
    localparam int W  = NW + 1;   // {err, result}

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [BW-1:0] req0_base, req1_base;
    logic [EW-1:0] req0_expo, req1_expo;
    logic [NW-1:0] req0_N, req1_N;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready, rsp1_ready;
    logic [NW-1:0] rsp_result;
    logic          rsp_err;
    logic          eng_start;
    logic [BW-1:0] eng_base;
    logic [EW-1:0] eng_expo;
    logic [NW-1:0] eng_N;
    logic [NW-1:0] eng_result;
    logic          eng_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];
    int           grant_log[$];

    // engine behaviour knobs
    int   eng_delay = 0;
    logic eng_hang  = 1'b0;

    // monitor statistics
    int cyc = 0;
    int grant_cyc = 0;
    int last_lat = -1;
    int n_r0 = 0, n_r1 = 0, n_start = 0, n_v0 = 0, n_v1 = 0;

    rsa_sched #(
        .base_width(BW),
        .expo_width(EW),
        .N_width   (NW),
        .TO_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req1_valid(req1_valid),
        .req0_base (req0_base),
        .req1_base (req1_base),
        .req0_expo (req0_expo),
        .req1_expo (req1_expo),
        .req0_N    (req0_N),
        .req1_N    (req1_N),
        .req0_ready(req0_ready),
        .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid),
        .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready),
        .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result),
        .rsp_err   (rsp_err),
        .eng_start (eng_start),
        .eng_base  (eng_base),
        .eng_expo  (eng_expo),
        .eng_N     (eng_N),
        .eng_result(eng_result),
        .eng_valid (eng_valid)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NW-1:0] modexp(input logic [BW-1:0] b,
                                             input logic [EW-1:0] e,
                                             input logic [NW-1:0] n);
        int r, bb, nn;
        nn = int'(n);
        if (nn == 0) return '0;
        r  = 1 % nn;
        bb = int'(b) % nn;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * bb) % nn;
            bb = (bb * bb) % nn;
        end
        return NW'(r);
    endfunction

    // behavioural engine: done becomes visible eng_delay cycles into WAIT
    int   eng_cnt;
    logic eng_busy;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_valid  <= 1'b0;
            eng_result <= '0;
            eng_busy   <= 1'b0;
            eng_cnt    <= 0;
        end else if (eng_start) begin
            eng_result <= modexp(eng_base, eng_expo, eng_N);
            if (eng_hang) begin
                eng_valid <= 1'b0;
                eng_busy  <= 1'b0;
            end else if (eng_delay == 0) begin
                eng_valid <= 1'b1;
                eng_busy  <= 1'b0;
            end else begin
                eng_valid <= 1'b0;
                eng_busy  <= 1'b1;
                eng_cnt   <= eng_delay - 1;
            end
        end else if (eng_busy) begin
            if (eng_cnt == 0) begin
                eng_valid <= 1'b1;
                eng_busy  <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    logic         prev_pending = 1'b0;
    logic         prev_port    = 1'b0;
    logic [W-1:0] prev_val     = '0;
    logic         prev_any     = 1'b0;
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst) begin
            prev_pending = 1'b0;
            prev_any     = 1'b0;
        end else begin
            if (req0_ready) begin n_r0++; grant_cyc = cyc; grant_log.push_back(0); end
            if (req1_ready) begin n_r1++; grant_cyc = cyc; grant_log.push_back(1); end
            if (eng_start) n_start++;
            if (rsp0_valid) n_v0++;
            if (rsp1_valid) n_v1++;
            if ((rsp0_valid || rsp1_valid) && !prev_any) last_lat = cyc - grant_cyc;
            if (rsp0_valid || rsp1_valid) check("one_rsp_valid", 32'(rsp0_valid & rsp1_valid), 32'(0));
            if (prev_pending) begin
                check("hold_valid", 32'(prev_port ? rsp1_valid : rsp0_valid), 32'(1));
                check("hold_data", 32'({rsp_err, rsp_result}), 32'(prev_val));
            end
            if (rsp0_valid && rsp0_ready) begin
                if (exp0_q.size() == 0) check("unexpected_rsp0", 32'(1), 32'(0));
                else begin e = exp0_q.pop_front(); check("rsp0_err_result", 32'({rsp_err, rsp_result}), 32'(e)); end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp1_q.size() == 0) check("unexpected_rsp1", 32'(1), 32'(0));
                else begin e = exp1_q.pop_front(); check("rsp1_err_result", 32'({rsp_err, rsp_result}), 32'(e)); end
            end
            prev_pending = (rsp0_valid && !rsp0_ready) || (rsp1_valid && !rsp1_ready);
            prev_port    = rsp1_valid;
            prev_val     = {rsp_err, rsp_result};
            prev_any     = rsp0_valid || rsp1_valid;
        end
    end

    // driver: present a job on requester k and hold it until granted
    task automatic issue(input int k, input logic [BW-1:0] b, input logic [EW-1:0] e,
                         input logic [NW-1:0] n);
        int g = 0;
        logic got = 1'b0;
        if (k == 0) begin req0_base = b; req0_expo = e; req0_N = n; req0_valid = 1'b1; end
        else        begin req1_base = b; req1_expo = e; req1_N = n; req1_valid = 1'b1; end
        while (!got && g < 1000) begin
            @(negedge clk);
            got = (k == 0) ? req0_ready : req1_ready;
            g++;
        end
        if (!got) check("grant_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
        if (k == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp0_q.size() != 0 || exp1_q.size() != 0) && g < 500) begin
            @(posedge clk);
            g++;
        end
        if (g >= 500) check("drain_timeout", 32'(0), 32'(1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req0_ready"}, 32'(req0_ready), 32'(0));
        check({tag, "_req1_ready"}, 32'(req1_ready), 32'(0));
        check({tag, "_rsp0_valid"}, 32'(rsp0_valid), 32'(0));
        check({tag, "_rsp1_valid"}, 32'(rsp1_valid), 32'(0));
        check({tag, "_eng_start"},  32'(eng_start),  32'(0));
        check({tag, "_eng_base"},   32'(eng_base),   32'(0));
        check({tag, "_eng_expo"},   32'(eng_expo),   32'(0));
        check({tag, "_eng_N"},      32'(eng_N),      32'(0));
        check({tag, "_rsp_result"}, 32'(rsp_result), 32'(0));
        check({tag, "_rsp_err"},    32'(rsp_err),    32'(0));
    endtask

    // global time limit
    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "time limit");
    end

    // directed sequence
    initial begin
        int s_r0, s_r1, s_st, s_v0, s_v1, g;
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_base = '0; req0_expo = '0; req0_N = '0;
        req1_base = '0; req1_expo = '0; req1_N = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0; req0_valid = 1'b0;

        // single job on requester 0, minimum latency
        eng_delay = 0; eng_hang = 1'b0;
        s_r0 = n_r0; s_r1 = n_r1; s_st = n_start; s_v1 = n_v1;
        exp0_q.push_back({1'b0, 6'd5});
        issue(0, 6'd3, 6'd5, 6'd7);
        wait_drain();
        check("a_req0_ready_pulses", 32'(n_r0 - s_r0), 32'(1));
        check("a_req1_ready_pulses", 32'(n_r1 - s_r1), 32'(0));
        check("a_eng_start_pulses", 32'(n_start - s_st), 32'(1));
        check("a_rsp1_valid_cycles", 32'(n_v1 - s_v1), 32'(0));
        check("a_latency", 32'(last_lat), 32'(3));

        // tie after reset: requester 0 first, then 1
        do_reset();
        grant_log.delete();
        exp0_q.push_back({1'b0, 6'd1});
        exp1_q.push_back({1'b0, 6'd5});
        fork
            issue(0, 6'd2, 6'd10, 6'd11);
            issue(1, 6'd3, 6'd5, 6'd7);
        join
        wait_drain();
        check("tie1_grants", 32'(grant_log.size()), 32'(2));
        if (grant_log.size() == 2) begin
            check("tie1_first", 32'(grant_log[0]), 32'(0));
            check("tie1_second", 32'(grant_log[1]), 32'(1));
        end

        // next tie goes to requester 0 again; modulus 1 and exponent 0 cases
        grant_log.delete();
        exp0_q.push_back({1'b0, 6'd0});
        exp1_q.push_back({1'b0, 6'd1});
        fork
            issue(0, 6'd4, 6'd0, 6'd1);
            issue(1, 6'd4, 6'd0, 6'd5);
        join
        wait_drain();
        check("tie2_grants", 32'(grant_log.size()), 32'(2));
        if (grant_log.size() == 2) begin
            check("tie2_first", 32'(grant_log[0]), 32'(0));
            check("tie2_second", 32'(grant_log[1]), 32'(1));
        end

        // after a lone requester-0 job, the tie goes to requester 1
        exp0_q.push_back({1'b0, 6'd1});
        issue(0, 6'd2, 6'd10, 6'd11);
        wait_drain();
        grant_log.delete();
        exp0_q.push_back({1'b0, 6'd5});
        exp1_q.push_back({1'b0, 6'd1});
        fork
            issue(0, 6'd3, 6'd5, 6'd7);
            issue(1, 6'd4, 6'd0, 6'd5);
        join
        wait_drain();
        check("tie3_grants", 32'(grant_log.size()), 32'(2));
        if (grant_log.size() == 2) begin
            check("tie3_first", 32'(grant_log[0]), 32'(1));
            check("tie3_second", 32'(grant_log[1]), 32'(0));
        end

        // watchdog expiry: engine never completes
        eng_hang = 1'b1;
        exp0_q.push_back({1'b1, 6'd0});
        issue(0, 6'd3, 6'd5, 6'd7);
        wait_drain();
        check("wd_latency", 32'(last_lat), 32'(TO + 2));

        // completion in the expiry cycle wins
        eng_hang = 1'b0; eng_delay = TO - 1;
        exp1_q.push_back({1'b0, 6'd5});
        issue(1, 6'd3, 6'd5, 6'd7);
        wait_drain();
        check("race_latency", 32'(last_lat), 32'(TO + 2));

        // completion one cycle before expiry
        eng_delay = TO - 2;
        exp0_q.push_back({1'b0, 6'd1});
        issue(0, 6'd2, 6'd10, 6'd11);
        wait_drain();
        check("late_latency", 32'(last_lat), 32'(TO + 1));

        // response back-pressure: hold 10 cycles while requester 1 waits
        eng_delay = 0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        exp0_q.push_back({1'b0, 6'd5});
        issue(0, 6'd3, 6'd5, 6'd7);
        g = 0;
        while (!rsp0_valid && g < 100) begin @(negedge clk); g++; end
        check("hold_rsp0_seen", 32'(rsp0_valid), 32'(1));
        s_r0 = n_r0; s_r1 = n_r1;
        exp1_q.push_back({1'b0, 6'd1});
        fork
            issue(1, 6'd2, 6'd10, 6'd11);
        join_none
        repeat (10) @(negedge clk);
        check("hold_rsp0_valid", 32'(rsp0_valid), 32'(1));
        check("hold_rsp_result", 32'(rsp_result), 32'(5));
        check("hold_no_req1_grant", 32'(n_r1 - s_r1), 32'(0));
        check("hold_no_req0_grant", 32'(n_r0 - s_r0), 32'(0));
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        wait fork;
        wait_drain();

        // reset in WAIT discards the job
        eng_hang = 1'b1;
        issue(0, 6'd3, 6'd5, 6'd7);
        repeat (5) @(posedge clk);
        #1;
        s_v0 = n_v0; s_v1 = n_v1;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0; eng_hang = 1'b0;
        repeat (TO + 10) @(posedge clk);
        #1;
        check("midrst_no_rsp0", 32'(n_v0 - s_v0), 32'(0));
        check("midrst_no_rsp1", 32'(n_v1 - s_v1), 32'(0));

        // fresh job after reset
        exp1_q.push_back({1'b0, 6'd1});
        issue(1, 6'd4, 6'd0, 6'd5);
        wait_drain();

        check("end_exp0_empty", 32'(exp0_q.size()), 32'(0));
        check("end_exp1_empty", 32'(exp1_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
